fc_accum_requant: RTL and testbench
===================================

FC_ACCUM_REQUANT -- requirements
Module: fc_accum_requant

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDRESS_BITS, 6, output feature-map bank address width.
- COLS_MAC, 4, number of output banks; power of two.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on the rising edge.
- rst, in, 1, asynchronous active-low reset.
- neuron_start, in, 1, pulse that latches the per-neuron config; accepted only in IDLE.
- bias, in, 32, signed neuron bias.
- iters, in, 16, number of partial MAC results to accumulate.
- frac, in, 8, arithmetic right-shift amount.
- relu_en, in, 1, apply ReLU before saturation.
- neuron_idx, in, 8, output neuron index.
- of_offset, in, ADDRESS_BITS, layer base address in the output map.
- mac_valid, in, 1, macs_result valid this cycle.
- macs_result, in, 32, signed partial sum from the PE array.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse when the output byte is written.
- sat_flag, out, 1, registered; last written result was clipped.
- en_w, out, COLS_MAC, per-bank write enable.
- of_write, out, 8 x COLS_MAC, per-bank write data.
- of_w_address, out, ADDRESS_BITS x COLS_MAC, per-bank write address.

Function
REQ-003 The FSM SHALL have states IDLE, ACCUM, ROUND and WRITE.
REQ-004 In IDLE, neuron_start SHALL latch all config inputs, load the 48-bit signed accumulator with sign-extended bias and clear the count. Next state is ACCUM, or ROUND if iters==0.
REQ-005 In ACCUM, each mac_valid cycle SHALL add sign-extended macs_result to the accumulator and increment the count. The cycle that makes count==iters SHALL transition to ROUND.
REQ-006 mac_valid outside ACCUM SHALL be ignored. neuron_start outside IDLE SHALL be ignored.
REQ-007 Shift amount s SHALL be min(frac, 47).
REQ-008 ROUND SHALL register r = (acc + (s>0 ? 2^(s-1) : 0)) >>> s, computed at 48-bit signed width.
REQ-009 If relu_en and r<0, r SHALL be forced to 0.
REQ-010 r SHALL then saturate to [-128, 127]. sat_flag SHALL be set iff clipping occurred; a ReLU clamp alone is not clipping.
REQ-011 The write target SHALL be bank b = neuron_idx mod COLS_MAC at address (of_offset + neuron_idx / COLS_MAC) mod 2^ADDRESS_BITS.
REQ-012 In WRITE, for exactly one cycle:
- en_w[b] = 1;
- of_write[b] = r[7:0];
- of_w_address[b] = the computed address;
- done = 1.
The next state SHALL be IDLE.
REQ-013 In every cycle other than WRITE, en_w SHALL be all-zero. of_write and of_w_address for non-enabled banks SHALL be 0.
REQ-014 Latency SHALL be: the last accepted mac_valid in cycle T gives en_w and done high in cycle T+2. With iters==0, neuron_start in cycle T gives the write in T+2.
REQ-015 A neuron_start presented in the WRITE cycle SHALL be ignored; back-to-back neurons need one IDLE cycle.

Reset
REQ-016 rst low SHALL, asynchronously:
- force IDLE;
- zero the accumulator, count and latched config;
- drive busy, done, sat_flag, en_w, of_write and of_w_address to 0.
REQ-017 Reset asserted mid-ACCUM or mid-ROUND SHALL produce no write. After release, the next neuron SHALL compute independently of the aborted one.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- bias=100, iters=3, macs 50,-20,70, frac=2, relu_en=0, neuron_idx=5, of_offset=8 -> r=50: en_w=4'b0010, of_write[1]=0x32, of_w_address[1]=9, done 2 cycles after the 3rd mac_valid, sat_flag=0.
- bias=0, iters=1, mac=100000, frac=4 -> 6250 saturates: of_write[b]=0x7F, sat_flag=1.
- bias=-1000, iters=1, mac=0, frac=0: relu_en=1 -> 0x00 with sat_flag=0; relu_en=0 -> 0x80 with sat_flag=1.
- iters=0, bias=-7, frac=1 -> (-7+1)>>>1=-3: of_write=0xFD, write 2 cycles after neuron_start.
- rst pulled low after 2 of 4 mac_valids -> no en_w, all outputs 0. The following neuron (bias=4, iters=1, mac=4, frac=1) writes 0x04.
- mac_valid pulses in IDLE and neuron_start while busy -> accumulator and config unchanged; result matches the unperturbed run.

Source files
------------

// File: rtl/fc_accum_requant_if.sv
`default_nettype none
// ============================================================================
// Module   : fc_accum_requant_if
// Brief    : Config, partial-sum and output-bank bus of the FC accumulate /
//            requantise stage. Master drives neuron config and MAC results,
//            slave returns status and the per-bank write port.
// Revision : 1.0 - initial release
// ============================================================================
interface fc_accum_requant_if #(
    parameter int ADDRESS_BITS = 6,
    parameter int COLS_MAC     = 4
);
    // Per-neuron configuration
    logic                                   neuron_start;
    logic [31:0]                            bias;
    logic [15:0]                            iters;
    logic [7:0]                             frac;
    logic                                   relu_en;
    logic [7:0]                             neuron_idx;
    logic [ADDRESS_BITS-1:0]                of_offset;
    // Partial sums from the PE array
    logic                                   mac_valid;
    logic [31:0]                            macs_result;
    // Status and output feature-map write port
    logic                                   busy;
    logic                                   done;
    logic                                   sat_flag;
    logic [COLS_MAC-1:0]                    en_w;
    logic [COLS_MAC-1:0][7:0]               of_write;
    logic [COLS_MAC-1:0][ADDRESS_BITS-1:0]  of_w_address;

    modport master (
        output neuron_start, bias, iters, frac, relu_en, neuron_idx, of_offset,
        output mac_valid, macs_result,
        input  busy, done, sat_flag, en_w, of_write, of_w_address
    );

    modport slave (
        input  neuron_start, bias, iters, frac, relu_en, neuron_idx, of_offset,
        input  mac_valid, macs_result,
        output busy, done, sat_flag, en_w, of_write, of_w_address
    );
endinterface
`default_nettype wire

// File: rtl/fc_accum_requant.sv
`default_nettype none
// ============================================================================
// Module   : fc_accum_requant
// Brief    : Accumulates a neuron's bias and partial MAC sums at 48 bits,
//            rounds and shifts by the fractional width, applies optional
//            ReLU, saturates to int8 and writes the byte into one bank of
//            the output feature map.
// Revision : 1.0 - initial release
// ============================================================================
module fc_accum_requant #(
    parameter int ADDRESS_BITS = 6,
    parameter int COLS_MAC     = 4
) (
    input  wire               clk,
    input  wire               rst,
    fc_accum_requant_if.slave bus
);

    localparam int         c_BANK_BITS = $clog2(COLS_MAC);
    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_ACCUM     = 2'd1;
    localparam logic [1:0] c_ROUND     = 2'd2;
    localparam logic [1:0] c_WRITE     = 2'd3;

    // State, accumulator and latched neuron configuration
    logic [1:0]                             r_state;
    logic signed [47:0]                     r_acc;
    logic [15:0]                            r_count;
    logic [15:0]                            r_iters;
    logic [7:0]                             r_frac;
    logic                                   r_relu_en;
    logic [7:0]                             r_neuron_idx;
    logic [ADDRESS_BITS-1:0]                r_of_offset;

    // Registered outputs
    logic                                   r_busy;
    logic                                   r_done;
    logic                                   r_sat;
    logic [COLS_MAC-1:0]                    r_en_w;
    logic [COLS_MAC-1:0][7:0]               r_of_write;
    logic [COLS_MAC-1:0][ADDRESS_BITS-1:0]  r_of_w_address;

    // Requantisation datapath
    logic [5:0]                             w_shamt;
    logic signed [47:0]                     w_round;
    logic signed [47:0]                     w_sum;
    logic signed [47:0]                     w_shift;
    logic signed [47:0]                     w_relu;
    logic [7:0]                             w_byte;
    logic                                   w_clip;
    logic [15:0]                            w_count_inc;

    // Output bank / address selection
    logic [7:0]                             w_bank;
    logic [7:0]                             w_row;
    logic [ADDRESS_BITS-1:0]                w_addr;
    logic [COLS_MAC-1:0]                    w_hit;

    assign w_count_inc = r_count + 16'd1;

    // Shifts beyond the accumulator width are pinned to 47 so the result
    // collapses to the sign rather than being undefined.
    assign w_shamt = (r_frac > 8'd47) ? 6'd47 : r_frac[5:0];
    assign w_round = (w_shamt != 6'd0) ? (48'sd1 <<< (w_shamt - 6'd1)) : 48'sd0;
    assign w_sum   = r_acc + w_round;
    assign w_shift = w_sum >>> w_shamt;
    assign w_relu  = (r_relu_en && w_shift[47]) ? 48'sd0 : w_shift;

    // Clip to int8; a ReLU clamp to zero never counts as clipping
    always_comb begin
        w_byte = w_relu[7:0];
        w_clip = 1'b0;
        if (w_relu > 48'sd127) begin
            w_byte = 8'h7F;
            w_clip = 1'b1;
        end else if (w_relu < -48'sd128) begin
            w_byte = 8'h80;
            w_clip = 1'b1;
        end
    end

    // Neurons are striped across banks; the row wraps inside the address space
    assign w_bank = r_neuron_idx & 8'(COLS_MAC - 1);
    assign w_row  = r_neuron_idx >> c_BANK_BITS;
    assign w_addr = r_of_offset + ADDRESS_BITS'(w_row);

    genvar g;
    generate
        for (g = 0; g < COLS_MAC; g++) begin : g_bank_sel
            assign w_hit[g] = (w_bank == 8'(g));
        end
    endgenerate

    // Control FSM with accumulator, config latch and registered write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= c_IDLE;
            r_acc          <= '0;
            r_count        <= '0;
            r_iters        <= '0;
            r_frac         <= '0;
            r_relu_en      <= 1'b0;
            r_neuron_idx   <= '0;
            r_of_offset    <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_sat          <= 1'b0;
            r_en_w         <= '0;
            r_of_write     <= '0;
            r_of_w_address <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.neuron_start) begin
                        r_acc        <= {{16{bus.bias[31]}}, bus.bias};
                        r_count      <= '0;
                        r_iters      <= bus.iters;
                        r_frac       <= bus.frac;
                        r_relu_en    <= bus.relu_en;
                        r_neuron_idx <= bus.neuron_idx;
                        r_of_offset  <= bus.of_offset;
                        r_busy       <= 1'b1;
                        r_state      <= (bus.iters == 16'd0) ? c_ROUND : c_ACCUM;
                    end
                end
                c_ACCUM: begin
                    if (bus.mac_valid) begin
                        r_acc   <= r_acc + {{16{bus.macs_result[31]}}, bus.macs_result};
                        r_count <= w_count_inc;
                        if (w_count_inc == r_iters) begin
                            r_state <= c_ROUND;
                        end
                    end
                end
                c_ROUND: begin
                    r_state <= c_WRITE;
                    r_done  <= 1'b1;
                    r_sat   <= w_clip;
                    r_en_w  <= w_hit;
                    for (int b = 0; b < COLS_MAC; b++) begin
                        r_of_write[b]     <= w_hit[b] ? w_byte : 8'd0;
                        r_of_w_address[b] <= w_hit[b] ? w_addr : '0;
                    end
                end
                c_WRITE: begin
                    r_state        <= c_IDLE;
                    r_busy         <= 1'b0;
                    r_done         <= 1'b0;
                    r_en_w         <= '0;
                    r_of_write     <= '0;
                    r_of_w_address <= '0;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.sat_flag     = r_sat;
    assign bus.en_w         = r_en_w;
    assign bus.of_write     = r_of_write;
    assign bus.of_w_address = r_of_w_address;

endmodule
`default_nettype wire

// File: tb/tb_fc_accum_requant.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_accum_requant
// Brief    : Directed self-checking bench for fc_accum_requant.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fc_accum_requant;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   fail_cnt;
    int   total_cnt;

    fc_accum_requant_if #(.ADDRESS_BITS(6), .COLS_MAC(4)) bus ();

    fc_accum_requant #(.ADDRESS_BITS(6), .COLS_MAC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] b, input logic [15:0] it, input logic [7:0] fr,
                         input logic rl, input logic [7:0] idx, input logic [5:0] off);
        bus.bias         = b;
        bus.iters        = it;
        bus.frac         = fr;
        bus.relu_en      = rl;
        bus.neuron_idx   = idx;
        bus.of_offset    = off;
        bus.neuron_start = 1'b1;
        tick();
        bus.neuron_start = 1'b0;
    endtask

    task automatic mac(input logic [31:0] v);
        bus.mac_valid   = 1'b1;
        bus.macs_result = v;
        tick();
        bus.mac_valid   = 1'b0;
        bus.macs_result = '0;
    endtask

    task automatic check_quiet(input string tag, input logic exp_busy);
        check({tag, "_en_w"}, 64'(bus.en_w), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'(exp_busy));
        check({tag, "_data"}, 64'(bus.of_write), 64'd0);
        check({tag, "_addr"}, 64'(bus.of_w_address), 64'd0);
    endtask

    // Checks the write-cycle contents; caller is positioned in the write cycle
    task automatic check_write(input string tag, input int bank, input logic [7:0] byt,
                               input logic [5:0] addr, input logic sat);
        logic [31:0] exp_data;
        logic [23:0] exp_addr;
        exp_data = '0;
        exp_addr = '0;
        exp_data[bank*8 +: 8] = byt;
        exp_addr[bank*6 +: 6] = addr;
        check({tag, "_en_w"}, 64'(bus.en_w), 64'(4'b0001 << bank));
        check({tag, "_done"}, 64'(bus.done), 64'd1);
        check({tag, "_data"}, 64'(bus.of_write), 64'(exp_data));
        check({tag, "_addr"}, 64'(bus.of_w_address), 64'(exp_addr));
        check({tag, "_sat"},  64'(bus.sat_flag), 64'(sat));
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    endtask

    // Called in the round cycle: nothing yet, write next cycle, then idle
    task automatic write_seq(input string tag, input int bank, input logic [7:0] byt,
                             input logic [5:0] addr, input logic sat);
        check_quiet({tag, "_pre"}, 1'b1);
        tick();
        check_write(tag, bank, byt, addr, sat);
        tick();
        check_quiet({tag, "_post"}, 1'b0);
        check({tag, "_sat_hold"}, 64'(bus.sat_flag), 64'(sat));
    endtask

    initial begin
        pass_cnt         = 0;
        fail_cnt         = 0;
        total_cnt        = 0;
        rst              = 1'b0;
        bus.neuron_start = 1'b0;
        bus.bias         = '0;
        bus.iters        = '0;
        bus.frac         = '0;
        bus.relu_en      = 1'b0;
        bus.neuron_idx   = '0;
        bus.of_offset    = '0;
        bus.mac_valid    = 1'b0;
        bus.macs_result  = '0;

        // Reset state
        tick();
        check_quiet("reset", 1'b0);
        check("reset_sat", 64'(bus.sat_flag), 64'd0);
        #2 rst = 1'b1;
        tick();

        // 100 + 50 - 20 + 70 = 200; (200+2)>>>2 = 50 -> bank 1, addr 8+1
        start(32'd100, 16'd3, 8'd2, 1'b0, 8'd5, 6'd8);
        check("s1_busy_accum", 64'(bus.busy), 64'd1);
        mac(32'd50);
        tick();
        mac(-32'sd20);
        check_quiet("s1_mid", 1'b1);
        mac(32'd70);
        write_seq("s1", 1, 8'h32, 6'd9, 1'b0);

        // 100000 + 8 >>> 4 = 6250 -> clipped to 127
        start(32'd0, 16'd1, 8'd4, 1'b0, 8'd2, 6'd0);
        mac(32'd100000);
        write_seq("s2", 2, 8'h7F, 6'd0, 1'b1);

        // -1000 with ReLU -> 0, not a clip
        start(-32'sd1000, 16'd1, 8'd0, 1'b1, 8'd7, 6'd3);
        mac(32'd0);
        write_seq("s3_relu", 3, 8'h00, 6'd4, 1'b0);

        // -1000 without ReLU -> clipped to -128
        start(-32'sd1000, 16'd1, 8'd0, 1'b0, 8'd0, 6'd63);
        mac(32'd0);
        write_seq("s3_norelu", 0, 8'h80, 6'd63, 1'b1);

        // iters=0: (-7+1)>>>1 = -3, write two cycles after start; addr 62+3 wraps to 1
        start(-32'sd7, 16'd0, 8'd1, 1'b0, 8'd13, 6'd62);
        write_seq("s4", 1, 8'hFD, 6'd1, 1'b0);

        // frac beyond 47 acts as 47: (-1 + 2^46) >>> 47 = 0
        start(-32'sd1, 16'd0, 8'd50, 1'b0, 8'd0, 6'd0);
        write_seq("s_bigfrac", 0, 8'h00, 6'd0, 1'b0);

        // Reset after two of four partial sums: everything clears, no write
        start(32'd999, 16'd4, 8'd0, 1'b0, 8'd2, 6'd0);
        mac(32'd10);
        mac(32'd20);
        #2 rst = 1'b0;
        #1;
        check_quiet("s5_rst_async", 1'b0);
        tick();
        check_quiet("s5_rst_hold", 1'b0);
        #3 rst = 1'b1;
        tick();
        check_quiet("s5_after1", 1'b0);
        tick();
        check_quiet("s5_after2", 1'b0);
        // Next neuron independent: (4+4+1)>>>1 = 4
        start(32'd4, 16'd1, 8'd1, 1'b0, 8'd1, 6'd0);
        mac(32'd4);
        write_seq("s5_next", 1, 8'h04, 6'd0, 1'b0);

        // Reset during the round cycle also drops the write
        start(32'd5, 16'd0, 8'd0, 1'b0, 8'd0, 6'd0);
        #2 rst = 1'b0;
        #1;
        check_quiet("s5b_rst_round", 1'b0);
        #3 rst = 1'b1;
        tick();
        check_quiet("s5b_after", 1'b0);

        // Stray mac_valid in IDLE, start and stray macs while busy
        bus.mac_valid   = 1'b1;
        bus.macs_result = 32'h7FFF_FFFF;
        tick();
        tick();
        bus.mac_valid   = 1'b0;
        check_quiet("s6_idle_mac", 1'b0);
        start(32'd100, 16'd3, 8'd2, 1'b0, 8'd5, 6'd8);
        bus.bias         = 32'd5000;
        bus.iters        = 16'd0;
        bus.frac         = 8'd0;
        bus.neuron_idx   = 8'd0;
        bus.of_offset    = 6'd20;
        bus.neuron_start = 1'b1;
        mac(32'd50);
        bus.neuron_start = 1'b0;
        mac(-32'sd20);
        mac(32'd70);
        // Round cycle: this partial sum must not be absorbed
        bus.mac_valid   = 1'b1;
        bus.macs_result = 32'd1000;
        check_quiet("s6_pre", 1'b1);
        tick();
        bus.mac_valid    = 1'b0;
        bus.macs_result  = '0;
        // Write cycle: this start must be dropped
        bus.neuron_start = 1'b1;
        check_write("s6", 1, 8'h32, 6'd9, 1'b0);
        tick();
        bus.neuron_start = 1'b0;
        check_quiet("s6_post", 1'b0);
        tick();
        check_quiet("s6_nostart", 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
